// File: rtl/vote_persistence_filter.sv
`default_nettype none
// ============================================================================
// Module   : vote_persistence_filter
// Purpose  : Debounces the 1-bit 2-of-3 majority vote with an ON/OFF
//            persistence state machine, producing a filtered `active` level.
//            It also counts filtered rising events (saturating) and flags
//            each one to a consumer over a valid/ready handshake.
// Ports    : clk          - clock, all state changes on the rising edge
//            reset        - synchronous reset, active low
//            in_val       - sample strobe; in_vote consumed only when 1
//            in_vote      - majority vote from the pair/triple detector
//            clear        - synchronous clear of event_count and pending flag
//            active       - filtered vote level (registered)
//            event_val    - rising event(s) pending acknowledgement
//            event_rdy    - consumer accepts the pending notification
//            event_count  - saturating count of filtered rising events
// Revision : 1.0 - initial release
// ============================================================================
module vote_persistence_filter #(
  parameter int N_ON  = 3,
  parameter int N_OFF = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_val,
  input  logic         in_vote,
  input  logic         clear,
  output logic         active,
  output logic         event_val,
  input  logic         event_rdy,
  output logic [W-1:0] event_count
);

  localparam logic [3:0]   C_N_ON    = 4'(N_ON);
  localparam logic [3:0]   C_N_OFF   = 4'(N_OFF);
  localparam logic [W-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_ARM    = 2'd1,
    S_ON     = 2'd2,
    S_DISARM = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic   [3:0]   r_run;
  logic   [3:0]   w_run_nxt;
  logic   [3:0]   w_run_inc;
  logic           w_rise;
  logic           w_active_nxt;
  logic           r_active;
  logic           r_event_val;
  logic   [W-1:0] r_event_count;

  assign w_run_inc = r_run + 4'd1;

  // Next-state logic. A low strobe holds state and run, so gaps never break
  // a run. w_rise marks entry into ON from OFF/ARM only.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_rise      = 1'b0;
    if (in_val) begin
      case (r_state)
        S_OFF: begin
          if (in_vote) begin
            if (C_N_ON == 4'd1) begin
              w_state_nxt = S_ON;
              w_run_nxt   = 4'd0;
              w_rise      = 1'b1;
            end else begin
              w_state_nxt = S_ARM;
              w_run_nxt   = 4'd1;
            end
          end
        end
        S_ARM: begin
          if (in_vote) begin
            if (w_run_inc >= C_N_ON) begin
              w_state_nxt = S_ON;
              w_run_nxt   = 4'd0;
              w_rise      = 1'b1;
            end else begin
              w_run_nxt   = w_run_inc;
            end
          end else begin
            w_state_nxt = S_OFF;
            w_run_nxt   = 4'd0;
          end
        end
        S_ON: begin
          if (!in_vote) begin
            if (C_N_OFF == 4'd1) begin
              w_state_nxt = S_OFF;
              w_run_nxt   = 4'd0;
            end else begin
              w_state_nxt = S_DISARM;
              w_run_nxt   = 4'd1;
            end
          end
        end
        S_DISARM: begin
          if (!in_vote) begin
            if (w_run_inc >= C_N_OFF) begin
              w_state_nxt = S_OFF;
              w_run_nxt   = 4'd0;
            end else begin
              w_run_nxt   = w_run_inc;
            end
          end else begin
            w_state_nxt = S_ON;
            w_run_nxt   = 4'd0;
          end
        end
        default: begin
          w_state_nxt = S_OFF;
          w_run_nxt   = 4'd0;
        end
      endcase
    end
  end

  // active is registered from the next state so it lines up with the edge
  // that samples the final vote of a run.
  assign w_active_nxt = (w_state_nxt == S_ON) || (w_state_nxt == S_DISARM);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= S_OFF;
      r_run         <= 4'd0;
      r_active      <= 1'b0;
      r_event_val   <= 1'b0;
      r_event_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_run    <= w_run_nxt;
      r_active <= w_active_nxt;

      // A rise coinciding with clear or an acknowledge must not be lost.
      if (clear) begin
        r_event_val <= w_rise;
      end else if (w_rise) begin
        r_event_val <= 1'b1;
      end else if (r_event_val && event_rdy) begin
        r_event_val <= 1'b0;
      end

      if (clear) begin
        r_event_count <= w_rise ? W'(1) : '0;
      end else if (w_rise && (r_event_count != C_CNT_MAX)) begin
        r_event_count <= r_event_count + W'(1);
      end
    end
  end

  assign active      = r_active;
  assign event_val   = r_event_val;
  assign event_count = r_event_count;

endmodule
`default_nettype wire
